ball_rom_arbiter: RTL and testbench
===================================

// Module: ball_rom_arbiter
// PURPOSE
//  Shares one single-port, 1-cycle-latency ball sprite ROM between N_REQ pixel-fetch requesters
//  (e.g. shooter-view and keeper-view ball draw blocks). Round-robin req/gnt arbitration, one grant
//  per clock, registered ROM address, data returned with a one-hot per-requester valid.
//  Sits between the draw_* blocks and the ball ROM, in the pixel clock domain.
// PARAMETERS
//  N_REQ       2   number of requesters (2..8)
//  ADDR_WIDTH  20  ROM address width
//  DATA_WIDTH  12  ROM data width (RGB444)
// PORTS
//  clk       in   1                 pixel clock, posedge active
//  rst       in   1                 asynchronous, active-high reset
//  req       in   N_REQ             per-requester read request, held until gnt
//  addr      in   N_REQ*ADDR_WIDTH  per-requester address, slice i = requester i, stable while req
//  lock      in   N_REQ             per-requester burst lock (used only with BALL_ARB_LOCK_EN)
//  gnt       out  N_REQ             one-hot, combinational: request i accepted this cycle
//  rom_addr  out  ADDR_WIDTH        registered address to ROM addrA
//  rom_dout  in   DATA_WIDTH        ROM dout (valid 1 cycle after rom_addr)
//  rd_data   out  DATA_WIDTH        returned pixel data (= rom_dout, not re-registered)
//  rd_valid  out  N_REQ             one-hot: rd_data belongs to requester i this cycle
// BEHAVIOUR
//  - Reset: rom_addr=0, addr_vld pipe=0, rd_valid=0, rr pointer last=N_REQ-1 (req 0 wins first).
//  - gnt: at most one bit set; zero when req==0. Priority order last+1, last+2, ... mod N_REQ.
//  - On grant of i in cycle T: edge T->T+1 rom_addr<=addr[i], last<=i, vld1<=onehot(i);
//    edge T+1->T+2 vld2<=vld1. rd_valid=vld2 in cycle T+2 with rd_data=rom_dout. Latency 2 cycles.
//  - Full throughput: back-to-back grants every cycle; in-flight reads never reorder.
//  - No grant: rom_addr holds its value; vld1 <= 0.
//  - Requester holding req after gnt is a new request; rotates like any other (fairness: max wait N_REQ-1 grants).
//  - Wrap-around: last=N_REQ-1 -> next search starts at 0.
//  - rst mid-operation: in-flight reads dropped (rd_valid forced 0 asynchronously), pointer reset; requesters reissue.
// CONFIGURATION
//  - BALL_ARB_LOCK_EN defined: FSM {ARB, LOCKED}. In ARB, grant to i with lock[i]=1 -> LOCKED(owner=i).
//    In LOCKED only owner may be granted (others see gnt=0); exit to ARB on the first cycle
//    lock[owner]=0 (that cycle is arbitrated normally, owner excluded from nothing). rst -> ARB.
//  - Undefined: lock port present but ignored; pure round-robin, no FSM.
// STRUCTURE
//  - ball_arb_pkg: typedef enum logic {ARB, LOCKED} arb_state_t; localparam MAX_REQ=8;
//    function onehot_to_idx.
//  - Sub-module rr_pick (combinational): inputs req, last; outputs gnt one-hot and idx.
//  - Top: pointer/FSM register, address mux+register, 2-stage valid pipe.
// TESTING
//  1 Reset: rst=1 mid-stream -> rd_valid=0, rom_addr=0 same cycle; after release req=2'b11 -> gnt=2'b01.
//  2 Single requester: req=2'b01, addr0=0x00010 at T -> rom_addr=0x00010 at T+1, rd_valid=2'b01 at T+2
//    with rd_data = ROM[0x10] (ROM model preloaded with data=addr[11:0]).
//  3 Contention: req=2'b11 held 6 cycles -> gnt 01,10,01,10,01,10; rd_valid same pattern 2 cycles later.
//  4 N_REQ=3, only req1,req2 active, last=2 -> gnt req1 next (wrap skips idle 0); no starvation in 100 cycles.
//  5 BALL_ARB_LOCK_EN: req0 lock=1 for 4 grants while req1 asserted -> gnt=01 x4, then lock0=0 -> gnt=10.
//  6 Random req/addr for 10k cycles vs scoreboard: every gnt yields exactly one rd_valid at +2, correct data.

Source files
------------

// File: rtl/ball_rom_arbiter_pkg.sv
// Shared types and helpers for the ball sprite ROM arbiter.
package ball_arb_pkg;

  typedef enum logic {ARB, LOCKED} arb_state_t;

  localparam int MAX_REQ = 8;
  localparam int MAX_IW  = $clog2(MAX_REQ);

  // OR-reduction of set-bit positions; exact for one-hot (and zero) inputs
  function automatic logic [MAX_IW-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | MAX_IW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ball_rom_arbiter_if.sv
// Requester-side bus of the ball ROM arbiter: req/addr/lock in, gnt and one-hot read return out.
interface ball_rom_arbiter_if #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 12
);
  logic [N_REQ-1:0]            req;
  logic [N_REQ*ADDR_WIDTH-1:0] addr;
  logic [N_REQ-1:0]            lock;
  logic [N_REQ-1:0]            gnt;
  logic [DATA_WIDTH-1:0]       rd_data;
  logic [N_REQ-1:0]            rd_valid;

  modport master (output req, addr, lock, input gnt, rd_data, rd_valid);
  modport slave  (input req, addr, lock, output gnt, rd_data, rd_valid);
endinterface

// File: rtl/ball_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: highest priority at last+1, wrapping modulo N_REQ.
module rr_pick
  import ball_arb_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0] j;

  // Scan from lowest to highest priority so the last hit wins
  always_comb begin
    gnt = '0;
    j   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = IW'((int'(last) + k) % N_REQ);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
      end
    end
  end

  assign idx = IW'(onehot_to_idx(MAX_REQ'(gnt)));

endmodule

// File: rtl/ball_rom_arbiter.sv
// Round-robin share of a 1-cycle ball ROM; data returns 2 cycles after gnt with one-hot rd_valid.
// Optional burst lock (owner keeps the ROM while lock is held) when BALL_ARB_LOCK_EN is defined.
module ball_rom_arbiter
  import ball_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  ball_rom_arbiter_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0]         last;
  logic [IW-1:0]         pick_idx;
  logic [IW-1:0]         g_idx;
  logic [N_REQ-1:0]      pick_gnt;
  logic [N_REQ-1:0]      g_vec;
  logic [N_REQ-1:0]      vld1;
  logic [N_REQ-1:0]      vld2;
  logic [ADDR_WIDTH-1:0] addr_sel;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req  (bus.req),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

`ifdef BALL_ARB_LOCK_EN
  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [IW-1:0] owner;

  // While the owner holds lock only it can be granted; the release cycle arbitrates normally
  always_comb begin
    state_nxt = state;
    g_vec     = pick_gnt;
    g_idx     = pick_idx;
    if (state == LOCKED && bus.lock[owner]) begin
      g_vec        = '0;
      g_vec[owner] = bus.req[owner];
      g_idx        = owner;
    end else begin
      state_nxt = (|pick_gnt && bus.lock[pick_idx]) ? LOCKED : ARB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB;
      owner <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == LOCKED && |g_vec) owner <= g_idx;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign g_vec       = pick_gnt;
  assign g_idx       = pick_idx;
`endif

  assign bus.gnt = g_vec;

  always_comb begin
    addr_sel = rom_addr;
    for (int i = 0; i < N_REQ; i++) begin
      if (g_vec[i]) addr_sel = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last     <= IW'(N_REQ - 1);
      rom_addr <= '0;
      vld1     <= '0;
      vld2     <= '0;
    end else begin
      rom_addr <= addr_sel;
      vld1     <= g_vec;
      vld2     <= vld1;
      if (|g_vec) last <= g_idx;
    end
  end

  // ROM dout lines up with vld2; passed through unregistered
  assign bus.rd_valid = vld2;
  assign bus.rd_data  = rom_dout;

endmodule

// File: tb/tb_ball_rom_arbiter.sv
// Scoreboard bench for ball_rom_arbiter (N_REQ=2 main instance, N_REQ=3 wrap/fairness instance).
module tb_ball_rom_arbiter;

  localparam int N  = 2;
  localparam int AW = 20;
  localparam int DW = 12;

  typedef struct {
    int            due;
    logic [N-1:0]  vld;
    logic [DW-1:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ball_rom_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  ball_rom_arbiter_if #(.N_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

  logic [AW-1:0] rom_addr, rom_addr3;
  logic [DW-1:0] rom_dout, rom_dout3;

  ball_rom_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .rom_addr(rom_addr), .rom_dout(rom_dout)
  );

  ball_rom_arbiter #(.N_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .rom_addr(rom_addr3), .rom_dout(rom_dout3)
  );

  // ROM models: 1-cycle latency, contents = address low bits
  always @(posedge clk) rom_dout  <= rom_addr[DW-1:0];
  always @(posedge clk) rom_dout3 <= rom_addr3[DW-1:0];

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rr_model(input logic [7:0] r, input int last, input int n);
    for (int k = 1; k <= n; k++) begin
      if (r[(last + k) % n]) return 8'd1 << ((last + k) % n);
    end
    return 8'd0;
  endfunction

  function automatic int oh_idx(input logic [7:0] oh);
    for (int i = 0; i < 8; i++) if (oh[i]) return i;
    return 0;
  endfunction

  // Reference state of the main instance
  exp_t          sb[$];
  exp_t          e;
  logic          mon_en   = 1'b0;
  int            mcyc     = 0;
  int            last_m   = N - 1;
  logic [AW-1:0] ra_m     = '0;
  logic          locked_m = 1'b0;
  int            owner_m  = 0;
  logic [7:0]    mg;
  int            gi;
  logic [AW-1:0] a_tmp;

  task automatic model_reset();
    sb.delete();
    mcyc     = 0;
    last_m   = N - 1;
    ra_m     = '0;
    locked_m = 1'b0;
    owner_m  = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mcyc++;
      if (sb.size() != 0 && sb[0].due == mcyc) begin
        e = sb.pop_front();
        chk("rd_valid", 32'(bus.rd_valid), 32'(e.vld));
        chk("rd_data", 32'(bus.rd_data), 32'(e.dat));
      end else begin
        chk("rd_idle", 32'(bus.rd_valid), 32'd0);
      end
      chk("rom_addr", 32'(rom_addr), 32'(ra_m));
      mg = rr_model(8'(bus.req), last_m, N);
`ifdef BALL_ARB_LOCK_EN
      if (locked_m && bus.lock[owner_m]) begin
        mg = bus.req[owner_m] ? (8'd1 << owner_m) : 8'd0;
      end else begin
        locked_m = 1'b0;
        if (mg != 0 && bus.lock[oh_idx(mg)]) begin
          locked_m = 1'b1;
          owner_m  = oh_idx(mg);
        end
      end
`endif
      chk("gnt", 32'(bus.gnt), 32'(mg));
      if (mg != 0) begin
        gi    = oh_idx(mg);
        a_tmp = bus.addr[gi*AW +: AW];
        sb.push_back('{due: mcyc + 2, vld: N'(mg), dat: a_tmp[DW-1:0]});
        ra_m   = a_tmp;
        last_m = gi;
      end
    end
  end

  logic [N-1:0] gs;
  logic [7:0]   mg3;
  int           last3;
  int           cnt3 [3];

  initial begin
    bus.req   = '0;
    bus.addr  = '0;
    bus.lock  = '0;
    bus3.req  = '0;
    bus3.addr = '0;
    bus3.lock = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    chk("reset_gnt_idle", 32'(bus.gnt), 32'd0);
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // N_REQ=3: only 1 and 2 request, pointer starts at 2 -> wrap skips idle 0
    bus3.req = 3'b110;
    last3    = 2;
    cnt3     = '{0, 0, 0};
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 0) chk("wrap3_first", 32'(bus3.gnt), 32'b010);
      mg3 = rr_model(8'(bus3.req), last3, 3);
      chk("gnt3", 32'(bus3.gnt), 32'(mg3));
      for (int i = 0; i < 3; i++) if (bus3.gnt[i]) cnt3[i]++;
      if (mg3 != 0) last3 = oh_idx(mg3);
      @(posedge clk);
      #1;
    end
    bus3.req = '0;
    chk("starve3_r0", 32'(cnt3[0]), 32'd0);
    chk("starve3_r1", 32'(cnt3[1]), 32'd50);
    chk("starve3_r2", 32'(cnt3[2]), 32'd50);

    // Single requester, 2-cycle latency
    bus.req          = 2'b01;
    bus.addr[0 +: AW] = 20'h00010;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.req = '0;
    @(negedge clk);
    chk("single_rom_addr", 32'(rom_addr), 32'h00010);
    @(negedge clk);
    chk("single_rd_valid", 32'(bus.rd_valid), 32'b01);
    chk("single_rd_data", 32'(bus.rd_data), 32'h010);
    @(posedge clk);
    #1;

    // Stream, then reset with reads in flight
    bus.req            = 2'b11;
    bus.addr[0 +: AW]  = 20'h0A5A5;
    bus.addr[AW +: AW] = 20'h1B3C7;
    repeat (3) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk("midrst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // Contention: alternate, starting with requester 0
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("contend_gnt", 32'(bus.gnt), (c % 2 == 0) ? 32'b01 : 32'b10);
      @(posedge clk);
      #1;
    end

`ifdef BALL_ARB_LOCK_EN
    // Requester 0 holds lock for 4 grants, then releases
    bus.lock = 2'b01;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) bus.lock = 2'b00;
      @(negedge clk);
      chk("lock_gnt", 32'(bus.gnt), (c < 4) ? 32'b01 : 32'b10);
      @(posedge clk);
      #1;
    end
`endif

    // Random traffic; requests held until granted
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      gs = bus.gnt;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] || gs[i]) begin
          bus.req[i]          = ($urandom_range(3) != 0);
          bus.addr[i*AW +: AW] = AW'($urandom);
        end
        if ($urandom_range(7) == 0) bus.lock[i] = ~bus.lock[i];
      end
    end

    bus.req  = '0;
    bus.lock = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
